// File: rtl/tdc_code_uart_tx.sv
// TDC readout: thermometer snapshot -> binary code -> small FIFO -> UART 8N1 serial output.
// The serialiser runs IDLE -> START -> DATA (8 bits, LSB first) -> STOP, one bit every CLKS_PER_BIT clocks.
module tdc_code_uart_tx #(
  parameter int THERMO_W     = 32,
  parameter int CODE_W       = 6,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [THERMO_W-1:0] thermo_in,
  input  logic                sample_valid,
  output logic                tx,
  output logic                busy,
  output logic                overflow,
  output logic [CNT_W-1:0]    fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                ovf_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];
  logic [CODE_W-1:0]   code;
  logic                push, push_ok, pop, full, empty, tmr_done;

  // Length of the run of ones from bit0; anything above the first zero is a bubble.
  function automatic logic [CODE_W-1:0] thermo_to_code(input logic [THERMO_W-1:0] t);
    logic [CODE_W-1:0] n;
    logic              run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < THERMO_W; i++) begin
      if (run && t[i]) n = n + CODE_W'(1);
      else             run = 1'b0;
    end
    return n;
  endfunction

  assign code     = thermo_to_code(thermo_in);
  assign push     = sample_valid && ena;
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == S_IDLE) && !empty;
  assign push_ok  = push && (!full || pop);
  assign tmr_done = (timer_q == '0);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
          timer_d = TMR_LOAD;
          shift_d = 8'(mem_q[rd_ptr_q]);
        end
      end
      S_START: begin
        if (tmr_done) begin
          state_d = S_DATA;
          idx_d   = '0;
          timer_d = TMR_LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_DATA: begin
        if (tmr_done) begin
          timer_d = TMR_LOAD;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_STOP: begin
        if (tmr_done) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx and busy are registered from the next state so they line up with it.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_q | (push && full && !pop);
      count_q  <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_ptr_q] <= code;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_tdc_code_uart_tx.sv
// Bench for tdc_code_uart_tx: cycle-level reference model (code queue + frame timeline)
// compared against tx/busy/fifo_count/overflow, plus directed scenarios.
module tb_tdc_code_uart_tx;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;
  localparam int TW    = 32;

  logic        clk = 1'b0;
  logic        rst_n, ena, sample_valid;
  logic [31:0] thermo_in;
  logic        tx, busy, overflow;
  logic [2:0]  fifo_count;

  tdc_code_uart_tx #(
    .THERMO_W(TW), .CODE_W(6), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .thermo_in(thermo_in),
    .sample_valid(sample_valid), .tx(tx), .busy(busy),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         frame_start = -100000;
  int         free_at  = 0;
  logic [7:0] frame_byte = 8'h00;
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;

  function automatic logic [7:0] ref_code(input logic [31:0] th);
    int n = 0;
    while (n < TW && th[n]) n++;
    return 8'(n);
  endfunction

  function automatic logic m_tx();
    int k = cyc - frame_start;
    if (k < 0 || k >= FRAME) return 1'b1;
    if (k < CPB)             return 1'b0;
    if (k < 9 * CPB)         return frame_byte[(k - CPB) / CPB];
    return 1'b1;
  endfunction

  function automatic logic m_busy();
    int k = cyc - frame_start;
    return (k >= 0 && k < FRAME) || (mq.size() != 0);
  endfunction

  function automatic logic [31:0] rand_thermo();
    int          k    = $urandom_range(0, 32);
    logic [63:0] ones = (64'd1 << k) - 64'd1;
    logic [63:0] keep = (64'd1 << (k + 1)) - 64'd1;
    logic [31:0] r    = $urandom;
    if ($urandom_range(0, 1) == 1) return ones[31:0] | (r & ~keep[31:0]);
    return ones[31:0];
  endfunction

  // Advance one clock and update the reference model with the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mq.delete();
      frame_start = -100000;
      free_at     = cyc + 1;
      m_ovf       = 1'b0;
    end else begin
      if (cyc >= free_at && mq.size() != 0) begin
        frame_byte  = mq.pop_front();
        frame_start = cyc;
        free_at     = cyc + FRAME + 1;
      end
      if (sample_valid && ena) begin
        if (mq.size() < DEPTH) mq.push_back(ref_code(thermo_in));
        else                   m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; sample_valid = 1'b0; thermo_in = '0;
    tick(); tick();
    rst_n = 1'b1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b expected 0", overflow); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", fifo_count); end
  endtask

  task automatic test_single_code(input logic [31:0] th, input logic [7:0] want, input string name);
    logic [7:0] got = 8'h00;
    int k;
    ena = 1'b1; thermo_in = th; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL %s count_after_push got %0d expected 1", name, fifo_count); end
    for (int n = 0; n < FRAME + 3; n++) begin
      tick();
      n_checks++; if (tx !== m_tx()) begin n_fail++; $display("FAIL %s tx got %b expected %b cycle %0d", name, tx, m_tx(), cyc); end
      n_checks++; if (busy !== m_busy()) begin n_fail++; $display("FAIL %s busy got %b expected %b cycle %0d", name, busy, m_busy(), cyc); end
      k = cyc - frame_start;
      if (k >= CPB && k < 9 * CPB && ((k - CPB) % CPB) == CPB / 2) got[(k - CPB) / CPB] = tx;
    end
    n_checks++; if (got !== want) begin n_fail++; $display("FAIL %s byte got %h expected %h", name, got, want); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_end got %b expected 0", name, busy); end
  endtask

  task automatic test_overflow();
    logic [31:0] ones = '0;
    int peak = 0;
    ena = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      ones = {ones[30:0], 1'b1};
      thermo_in = ones; sample_valid = 1'b1;
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (i < 6) begin
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early strobe %0d got %b expected 0", i, overflow); end
      end else begin
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b expected 1", overflow); end
      end
    end
    sample_valid = 1'b0;
    for (int n = 0; n < 5 * (FRAME + 1) + 10; n++) begin
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      n_checks++; if (tx !== m_tx()) begin n_fail++; $display("FAIL ovf tx got %b expected %b cycle %0d", tx, m_tx(), cyc); end
      n_checks++; if (busy !== m_busy()) begin n_fail++; $display("FAIL ovf busy got %b expected %b cycle %0d", busy, m_busy(), cyc); end
      n_checks++; if (fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL ovf count got %0d expected %0d cycle %0d", fifo_count, mq.size(), cyc); end
    end
    n_checks++; if (peak !== 4) begin n_fail++; $display("FAIL ovf_peak got %0d expected 4", peak); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b expected 1", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    int w = 0;
    ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      thermo_in = rand_thermo(); sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    while ((cyc - frame_start) != CPB * 4 + 5 && w < 300) begin
      tick();
      n_checks++; if (tx !== m_tx()) begin n_fail++; $display("FAIL midrst tx got %b expected %b cycle %0d", tx, m_tx(), cyc); end
      w++;
    end
    n_checks++; if (w >= 300) begin n_fail++; $display("FAIL midrst timeout waited %0d required <300", w); end
    n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL midrst queued got %0d expected 2", fifo_count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b expected 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count got %0d expected 0", fifo_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf got %b expected 0", overflow); end
    for (int n = 0; n < 2 * FRAME; n++) begin
      tick();
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_quiet tx got %b expected 1 cycle %0d", tx, cyc); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet busy got %b expected 0 cycle %0d", busy, cyc); end
    end
  endtask

  task automatic test_ena();
    logic [31:0] th0;
    logic [7:0]  got = 8'h00;
    int k;
    ena = 1'b0; sample_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      thermo_in = rand_thermo();
      tick();
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL ena_off count got %0d expected 0", fifo_count); end
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL ena_off tx got %b expected 1", tx); end
    end
    ena = 1'b1; th0 = rand_thermo(); thermo_in = th0; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int n = 0; n < FRAME + 5; n++) begin
      if (n >= 40) begin ena = 1'b0; sample_valid = 1'b1; thermo_in = rand_thermo(); end
      tick();
      n_checks++; if (tx !== m_tx()) begin n_fail++; $display("FAIL ena_drop tx got %b expected %b cycle %0d", tx, m_tx(), cyc); end
      n_checks++; if (fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL ena_drop count got %0d expected %0d", fifo_count, mq.size()); end
      k = cyc - frame_start;
      if (k >= CPB && k < 9 * CPB && ((k - CPB) % CPB) == CPB / 2) got[(k - CPB) / CPB] = tx;
    end
    n_checks++; if (got !== ref_code(th0)) begin n_fail++; $display("FAIL ena_drop byte got %h expected %h", got, ref_code(th0)); end
    ena = 1'b1; sample_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2500 + 6 * (FRAME + 1); n++) begin
      if (n < 2500) begin
        ena          = ($urandom_range(0, 9) != 0);
        sample_valid = ($urandom_range(0, 59) == 0);
        thermo_in    = rand_thermo();
      end else begin
        sample_valid = 1'b0;
      end
      tick();
      n_checks++; if (tx !== m_tx()) begin n_fail++; $display("FAIL b2b tx got %b expected %b cycle %0d", tx, m_tx(), cyc); end
      n_checks++; if (busy !== m_busy()) begin n_fail++; $display("FAIL b2b busy got %b expected %b cycle %0d", busy, m_busy(), cyc); end
      n_checks++; if (fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL b2b count got %0d expected %0d cycle %0d", fifo_count, mq.size(), cyc); end
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL b2b overflow got %b expected %b cycle %0d", overflow, m_ovf, cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_single_code(32'h0000_00FF, 8'h08, "t1_ff");
    test_single_code(32'hFFFF_FFFF, 8'h20, "t2_ones");
    test_single_code(32'h0000_0000, 8'h00, "t3_zero");
    test_single_code(32'h0000_00F7, 8'h03, "t4_bubble");
    test_overflow();
    test_reset_mid_frame();
    test_ena();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
